// File: rtl/data_transfer_manager.sv
// Responder side of the DTM handshake: pops one trigger record and emits a framed
// packet (2 header words, N pass-through payload words, XOR checksum trailer).
module data_transfer_manager #(
    parameter logic [7:0]  HDR_TAG = 8'hA5,
    parameter int unsigned LEN_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_dtm,
    input  logic [31:0] csn,
    input  logic        tm_fifo_valid,
    input  logic [31:0] tm_fifo_data,
    output logic        tm_fifo_rd_en,
    input  logic [31:0] chan_data,
    input  logic        chan_valid,
    output logic        chan_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        dtm_done,
    output logic        busy,
    output logic [31:0] pkt_count
);

    localparam int unsigned TRIG_W = 24;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR0    = 3'd1;
    localparam logic [2:0] S_HDR1    = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_TRAILER = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [TRIG_W-1:0] trig_q, trig_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       csn_q, csn_d;
    logic [31:0]       chk_q, chk_d;
    logic [31:0]       pkt_q, pkt_d;

    // State and packet context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            trig_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            csn_q   <= '0;
            chk_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csn_q   <= csn_d;
            chk_q   <= chk_d;
            pkt_q   <= pkt_d;
        end
    end

    assign pkt_count = pkt_q;

    // Next-state and stream outputs; header/trailer words come straight from registers
    always_comb begin
        state_d       = state_q;
        trig_d        = trig_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        csn_d         = csn_q;
        chk_d         = chk_q;
        pkt_d         = pkt_q;
        tm_fifo_rd_en = 1'b0;
        chan_ready    = 1'b0;
        tx_data       = '0;
        tx_valid      = 1'b0;
        tx_last       = 1'b0;
        dtm_done      = 1'b0;
        busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // rst_n gating keeps the pop strobe low while reset is held
                if (rst_n && run_dtm && tm_fifo_valid) begin
                    tm_fifo_rd_en = 1'b1;
                    trig_d        = tm_fifo_data[TRIG_W-1:0];
                    len_d         = tm_fifo_data[31 -: LEN_W];
                    csn_d         = csn;
                    cnt_d         = '0;
                    state_d       = S_HDR0;
                end
            end
            S_HDR0: begin
                tx_valid = 1'b1;
                tx_data  = {HDR_TAG, trig_q};
                if (tx_ready) begin
                    chk_d   = {HDR_TAG, trig_q};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                tx_valid = 1'b1;
                tx_data  = csn_q;
                if (tx_ready) begin
                    chk_d   = chk_q ^ csn_q;
                    state_d = (len_q != '0) ? S_PAYLOAD : S_TRAILER;
                end
            end
            S_PAYLOAD: begin
                tx_valid   = chan_valid;
                tx_data    = chan_data;
                chan_ready = tx_ready;
                if (chan_valid && tx_ready) begin
                    chk_d = chk_q ^ chan_data;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_TRAILER;
                    end
                end
            end
            S_TRAILER: begin
                tx_valid = 1'b1;
                tx_last  = 1'b1;
                tx_data  = chk_q;
                if (tx_ready) begin
                    pkt_d   = pkt_q + 32'd1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                dtm_done = 1'b1;
                if (!run_dtm) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_transfer_manager.sv
// Directed bench for data_transfer_manager: framed packets, backpressure, empty FIFO,
// early release and mid-packet reset, all against hand-computed words.
`timescale 1ns/1ps
module tb_data_transfer_manager;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic        run_dtm       = 1'b0;
    logic [31:0] csn           = '0;
    logic        tm_fifo_valid = 1'b0;
    logic [31:0] tm_fifo_data  = '0;
    logic        tm_fifo_rd_en;
    logic [31:0] chan_data     = '0;
    logic        chan_valid    = 1'b0;
    logic        chan_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready      = 1'b1;
    logic        dtm_done;
    logic        busy;
    logic [31:0] pkt_count;

    always #5 clk = ~clk;

    data_transfer_manager dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_dtm       (run_dtm),
        .csn           (csn),
        .tm_fifo_valid (tm_fifo_valid),
        .tm_fifo_data  (tm_fifo_data),
        .tm_fifo_rd_en (tm_fifo_rd_en),
        .chan_data     (chan_data),
        .chan_valid    (chan_valid),
        .chan_ready    (chan_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .dtm_done      (dtm_done),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pl[$];
    int          pl_idx   = 0;
    bit          gaps     = 1'b0;
    bit          bp       = 1'b0;
    bit          chan_fire_s = 1'b0;
    logic [31:0] words[$];
    logic        lasts[$];
    int          rd_cnt   = 0;
    int          cr_cnt   = 0;
    bit          hold_pending = 1'b0;
    logic [31:0] held     = '0;
    int          exp_pkt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Negedge monitor: records transfers, pops, and stability under backpressure
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
            chan_fire_s  = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", tx_data, held);
            end
            hold_pending = tx_valid && !tx_ready;
            held         = tx_data;
            chan_fire_s  = chan_valid && chan_ready;
            if (tx_valid && tx_ready) begin
                words.push_back(tx_data);
                lasts.push_back(tx_last);
            end
            if (tm_fifo_rd_en) rd_cnt++;
            if (chan_ready) cr_cnt++;
        end
    end

    // Advance one clock, then update the channel source and downstream ready
    task automatic tick();
        bit fired;
        @(posedge clk);
        #1;
        fired = chan_fire_s;
        if (fired) pl_idx++;
        if (!(chan_valid && !fired)) begin
            chan_valid = (pl_idx < pl.size()) && (!gaps || ($urandom_range(0, 2) != 0));
            chan_data  = chan_valid ? pl[pl_idx] : 32'hDEAD_BEEF;
        end
        tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_packet(input string name, input logic [31:0] fdata, input logic [31:0] c,
                             input logic [31:0] exp_chk, input bit early);
        int          n;
        bit          seen_done;
        logic [31:0] exp_w;
        n         = int'(fdata[31:24]);
        seen_done = 1'b0;
        words.delete();
        lasts.delete();
        rd_cnt     = 0;
        cr_cnt     = 0;
        pl_idx     = 0;
        chan_valid = 1'b0;
        tm_fifo_data  = fdata;
        tm_fifo_valid = 1'b1;
        csn           = c;
        run_dtm       = 1'b1;
        tick();
        check({name, "_hdr0_valid"}, 32'(tx_valid), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd1);
        tm_fifo_valid = 1'b0;
        tm_fifo_data  = 32'hFFFF_FFFF;
        csn           = 32'h1234_5678;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (dtm_done) begin
                seen_done = 1'b1;
                break;
            end
            if (early && pl_idx >= 1) run_dtm = 1'b0;
        end
        check({name, "_done_seen"}, 32'(seen_done), 32'd1);
        check({name, "_nwords"}, 32'(words.size()), 32'(n + 3));
        for (int i = 0; i < n + 3 && i < words.size(); i++) begin
            if (i == 0)          exp_w = {8'hA5, fdata[23:0]};
            else if (i == 1)     exp_w = c;
            else if (i == n + 2) exp_w = exp_chk;
            else                 exp_w = pl[i - 2];
            check($sformatf("%s_word%0d", name, i), words[i], exp_w);
            check($sformatf("%s_last%0d", name, i), 32'(lasts[i]), 32'(i == n + 2));
        end
        check({name, "_rd_pulses"}, 32'(rd_cnt), 32'd1);
        if (n == 0) check({name, "_chan_ready"}, 32'(cr_cnt), 32'd0);
        exp_pkt++;
        check({name, "_pkt_count"}, pkt_count, 32'(exp_pkt));
        if (early) begin
            tick();
            check({name, "_done_pulse"}, 32'(dtm_done), 32'd0);
        end else begin
            repeat (3) begin
                tick();
                check({name, "_done_hold"}, 32'(dtm_done), 32'd1);
            end
            run_dtm = 1'b0;
            tick();
            check({name, "_done_clr"}, 32'(dtm_done), 32'd0);
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_count", pkt_count, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        pl = '{32'd1, 32'd2, 32'd3};
        do_packet("basic", 32'h0300_0010, 32'd5, 32'hA500_0015, 1'b0);

        pl.delete();
        do_packet("zero", 32'h0000_0007, 32'hA, 32'hA500_000D, 1'b0);

        pl = '{32'd1, 32'd2, 32'd3};
        bp   = 1'b1;
        gaps = 1'b1;
        do_packet("bp", 32'h0300_0010, 32'd5, 32'hA500_0015, 1'b0);
        bp   = 1'b0;
        gaps = 1'b0;
        tick();

        // Request pending with an empty FIFO: no pop, stay idle
        run_dtm = 1'b1;
        rd_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("empty_busy", 32'(busy), 32'd0);
            check("empty_rd_en", 32'(tm_fifo_rd_en), 32'd0);
        end
        check("empty_no_pop", 32'(rd_cnt), 32'd0);
        pl = '{32'hCAFE_0000};
        do_packet("empty", 32'h0100_0042, 32'h3, 32'h6FFE_0041, 1'b0);

        pl = '{32'h10, 32'h20, 32'h30, 32'h40};
        do_packet("early", 32'h0400_0022, 32'h11, 32'hA500_0073, 1'b1);

        // Reset while HDR1 is stalled
        pl = '{32'h1};
        pl_idx        = 0;
        tm_fifo_data  = 32'h0100_0055;
        tm_fifo_valid = 1'b1;
        csn           = 32'h77;
        run_dtm       = 1'b1;
        tick();
        tm_fifo_valid = 1'b0;
        tick();
        tx_ready = 1'b0;
        check("rst_pre_hdr1", tx_data, 32'h77);
        #2;
        rst_n         = 1'b0;
        tm_fifo_valid = 1'b1;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_data", tx_data, 32'd0);
        check("midrst_tx_last", 32'(tx_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(dtm_done), 32'd0);
        check("midrst_chan_ready", 32'(chan_ready), 32'd0);
        check("midrst_rd_en", 32'(tm_fifo_rd_en), 32'd0);
        check("midrst_pkt_count", pkt_count, 32'd0);
        run_dtm       = 1'b0;
        tm_fifo_valid = 1'b0;
        tx_ready      = 1'b1;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_pkt = 0;
        tick();
        pl = '{32'hF0F0_F0F0, 32'h0F0F_0F0F};
        do_packet("post_rst", 32'h0200_0100, 32'h99, 32'h5AFF_FE66, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_transfer_manager.md
Name: data_transfer_manager

Overview:
- Responder side of the command-manager DTM handshake.
- On `run_dtm`, pops one trigger record from the trigger-manager FIFO and emits one framed packet on a valid/ready stream: 2 header words, N payload words passed through from the channel readout, 1 XOR-checksum trailer.
- Asserts `dtm_done` after the trailer is accepted, and holds it until `run_dtm` is released.

Parameters:
- HDR_TAG, 8'hA5, upper byte of header word 0.
- LEN_W, 8, width of the payload-length field taken from FIFO data[31:24]. Fixed at 8; exposed for documentation only.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run_dtm  in  1  transfer request from the command manager.
- csn  in  32  command sequence number; sampled at packet start.
- tm_fifo_valid  in  1  trigger FIFO not empty.
- tm_fifo_data  in  32  [31:24] payload length N (0..255); [23:0] trigger number.
- tm_fifo_rd_en  out  1  one-cycle FIFO pop (first-word-fall-through FIFO).
- chan_data  in  32  payload word from the channel readout.
- chan_valid  in  1  `chan_data` valid.
- chan_ready  out  1  payload word consumed.
- tx_data  out  32  packet stream data.
- tx_valid  out  1  stream valid.
- tx_last  out  1  high on the trailer word only.
- tx_ready  in  1  downstream accepts the word.
- dtm_done  out  1  packet complete; held until `run_dtm` is low.
- busy  out  1  high in every state except IDLE.
- pkt_count  out  32  number of completed packets; wraps from 0xFFFFFFFF to 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: tm_fifo_rd_en, chan_ready, tx_valid, tx_last, tx_data, dtm_done, busy, pkt_count.
  - Internal latches (trigger number, length, csn, word counter, checksum) are cleared.
  - A reset mid-packet abandons the packet. No trailer is sent and no `dtm_done` is issued.
- A word transfers on a clock edge where tx_valid && tx_ready.
- Once tx_valid is high in HDR0, HDR1 or TRAILER, tx_data and tx_valid stay stable until the word transfers.
- States:
  - IDLE: when run_dtm && tm_fifo_valid, drive tm_fifo_rd_en=1 for exactly that cycle. On the same edge latch:
    - trig ← data[23:0]
    - len ← data[31:24]
    - csn_l ← csn
    - cnt ← 0
    Then go to HDR0. With run_dtm=1 and the FIFO empty, stay in IDLE and do not pop.
  - HDR0: tx_valid=1, tx_data={HDR_TAG, trig}. On transfer: chk ← tx_data, go to HDR1.
  - HDR1: tx_valid=1, tx_data=csn_l. On transfer: chk ← chk ^ csn_l. Go to PAYLOAD if len≠0, else TRAILER.
  - PAYLOAD: combinational pass-through.
    - tx_data=chan_data, tx_valid=chan_valid, chan_ready=tx_ready.
    - On transfer: chk ^= chan_data, cnt+1.
    - On the transfer where cnt==len-1, go to TRAILER.
    - chan_ready is 0 in all other states.
  - TRAILER: tx_valid=1, tx_last=1, tx_data=chk. On transfer: pkt_count+1, go to DONE.
  - DONE: dtm_done=1. When run_dtm=0, go to IDLE (dtm_done=0 from the next cycle).
- If run_dtm deasserts before DONE, the packet still completes. DONE is then entered with run_dtm low, giving a 1-cycle dtm_done pulse.
- In IDLE, a new request is accepted only after DONE has exited. Back-to-back packets therefore have at least one IDLE cycle between them.
- Latency: request in IDLE → HDR0 tx_valid on the next cycle. Trailer accepted → dtm_done high on the next cycle.
- csn or tm_fifo_data changing after the IDLE sample has no effect on the current packet.

Test Plan:
- Basic 3-word packet:
  - Stimulus: tm_fifo_data=0x03000010, csn=5, payload 1,2,3, tx_ready=1.
  - Required: single rd_en pulse; stream A5000010, 00000005, 1, 2, 3, A5000015; tx_last on the last word only; dtm_done high until run_dtm drops; pkt_count=1.
- Zero-length packet:
  - Stimulus: tm_fifo_data=0x00000007, csn=0xA.
  - Required: stream A5000007, 0000000A, A500000D; chan_ready never asserted.
- Backpressure:
  - Stimulus: as the basic packet, with tx_ready toggled pseudo-randomly and gaps on chan_valid.
  - Required: identical words; tx_data stable while tx_valid && !tx_ready; no duplicated or dropped payload word.
- Empty FIFO:
  - Stimulus: run_dtm=1, tm_fifo_valid=0 for 10 cycles, then valid.
  - Required: no pop and busy=0 during the wait; packet starts one cycle after valid.
- Early release:
  - Stimulus: run_dtm deasserted during PAYLOAD.
  - Required: packet completes; dtm_done is a 1-cycle pulse; return to IDLE.
- Reset mid-packet:
  - Stimulus: rst_n low during HDR1.
  - Required: outputs 0 immediately (asynchronous); pkt_count=0; the next request produces a full, correct packet.
